rosetta_ext_burst_master: RTL and testbench
===========================================

// Module: rosetta_ext_burst_master
// PURPOSE
//  Host-side initiator for the 512b external BRAM-style memory port of the ROSETTA wrapper.
//  Turns valid/ready burst commands and write-data streams into ext_en/ext_we/ext_addr beats.
//  Collects read data after a fixed read latency into an output FIFO with backpressure.
//  Sits between the host DMA/loader and the ROSETTA wrapper 512b port (AM0/AM1/WM/BM regions).
// PARAMETERS
//  RD_LAT    1  cycles from ext_en (read) to valid ext_rdata_512b; legal range 1..4
//  RDQ_DEPTH 4  read FIFO depth in beats; must be >= RD_LAT+1 and a power of 2
// PORTS
//  ext_clk         in   1    clock, rising edge
//  ext_rst_n       in   1    reset; one clock; reset is asynchronous and active-low
//  cmd_valid       in   1    command valid
//  cmd_ready       out  1    command accepted when valid&ready
//  cmd_write       in   1    1=write burst, 0=read burst
//  cmd_addr        in   19   byte start address; bits [5:0] ignored (treated as 0)
//  cmd_len         in   8    beats-1 (1..256 beats)
//  cmd_err         out  1    1-cycle pulse: command rejected (BOUNDARY_CHECK_EN only)
//  wr_valid        in   1    write beat valid
//  wr_ready        out  1    write beat accepted when valid&ready
//  wr_data         in   512  write beat data
//  wr_strb         in   64   write beat byte enables
//  rd_valid        out  1    read beat valid (FIFO head)
//  rd_ready        in   1    read beat consumed when valid&ready
//  rd_data         out  512  read beat data
//  rd_last         out  1    head beat is last of its burst
//  busy            out  1    FSM not IDLE or reads in flight
//  ext_addr_512b   out  19   registered byte address, [5:0]=0
//  ext_wdata_512b  out  512  registered write data
//  ext_we_512b     out  64   registered byte write enables (0 on reads)
//  ext_en_512b     out  1    registered access enable
//  ext_rdata_512b  in   512  read data from memory port
// BEHAVIOUR
//  Reset: all ext_* outputs, rd_valid, rd_last, cmd_err, busy, wr_ready = 0; FIFO and counters empty.
//   cmd_ready = 0 while ext_rst_n low. In-flight reads are discarded by reset.
//  FSM states: IDLE, WRITE, READ, DRAIN.
//   IDLE: cmd_ready=1; on accept latch addr[18:6], len into beat counter; go WRITE or READ.
//   WRITE: wr_ready=1. Each accepted beat drives ext_en=1, ext_we=wr_strb, ext_wdata, ext_addr next cycle.
//    - wr_strb==0: beat consumed, ext_en=0 (the port would treat it as a read), address still advances.
//    - No wr_valid: ext_en=0 that cycle; no address advance. After last beat -> IDLE.
//   READ: issue one beat/cycle (ext_en=1, ext_we=0) only while inflight+fifo_count < RDQ_DEPTH.
//    - After the last issue -> DRAIN. DRAIN -> IDLE when inflight==0.
//  Read capture: RD_LAT-deep valid/last shift pipe; ext_rdata_512b sampled RD_LAT cycles after ext_en.
//   Sampled data is pushed into the FIFO; rd_valid rises the cycle after the push.
//  Latency: command accept at T -> first read ext_en at T+1; first write ext_en at T+2 (wr_valid held).
//  Address increments by 64 per beat, modulo 2^19 (0x7FFC0 -> 0x00000).
//  Simultaneous FIFO push and pop at full or empty are legal; count is unchanged.
//  cmd_ready is low outside IDLE; there are no overlapping commands.
//  rd_ready may stall indefinitely; issue throttles, data is never lost.
// CONFIGURATION
//  ROSETTA_EXT_BOUNDARY_CHECK_EN defined: a command whose burst crosses a 128 KiB region
//   (start addr[18:17] != end addr[18:17]) is accepted but not executed; cmd_err pulses one cycle.
//   A rejected write enters WRITE and consumes/discards len+1 beats with ext_en=0.
//   A rejected read returns directly to IDLE.
//  Undefined: no check, cmd_err tied 0, address wraps freely modulo 2^19.
// TESTING
//  Write len=3 @0x00040, strb all-ones -> ext_en beats at 0x40,0x80,0xC0,0x100, we=0xFFFF_FFFF_FFFF_FFFF.
//  Read len=7 @0x20000, rd_ready=1, RD_LAT=1 -> 8 rd beats in order, rd_last on the 8th only, busy falls after.
//  Read len=15 with rd_ready=0 -> exactly RDQ_DEPTH ext_en beats issued, then stall; release -> 16 beats, no loss.
//  Write beat with wr_strb=0 mid-burst -> ext_en=0 that beat, next beat's address still skips by 64.
//  Read len=1 @0x7FFC0 -> addresses 0x7FFC0, 0x00000 (macro off); with macro on -> cmd_err=1, no ext_en.
//  Assert ext_rst_n low mid read burst -> all outputs 0 immediately, rd_valid=0, cmd_ready=1 after release.

Source files
------------

// File: rtl/rosetta_ext_burst_master_if.sv
// Host command/write/read streams and the 512b external memory port of the ROSETTA burst master.
// The master modport is the burst master's view; slave is the host plus memory side.
interface rosetta_ext_burst_master_if;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_write;
    logic [18:0]  cmd_addr;
    logic [7:0]   cmd_len;
    logic         cmd_err;
    logic         wr_valid;
    logic         wr_ready;
    logic [511:0] wr_data;
    logic [63:0]  wr_strb;
    logic         rd_valid;
    logic         rd_ready;
    logic [511:0] rd_data;
    logic         rd_last;
    logic         busy;
    logic [18:0]  ext_addr_512b;
    logic [511:0] ext_wdata_512b;
    logic [63:0]  ext_we_512b;
    logic         ext_en_512b;
    logic [511:0] ext_rdata_512b;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wr_valid, wr_data, wr_strb,
        input  rd_ready, ext_rdata_512b,
        output cmd_ready, cmd_err, wr_ready,
        output rd_valid, rd_data, rd_last, busy,
        output ext_addr_512b, ext_wdata_512b, ext_we_512b, ext_en_512b
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wr_valid, wr_data, wr_strb,
        output rd_ready, ext_rdata_512b,
        input  cmd_ready, cmd_err, wr_ready,
        input  rd_valid, rd_data, rd_last, busy,
        input  ext_addr_512b, ext_wdata_512b, ext_we_512b, ext_en_512b
    );
endinterface

// File: rtl/rosetta_ext_burst_master.sv
// Burst initiator for the ROSETTA 512b external memory port: commands -> ext_* beats, read data -> FIFO.
// Optional ROSETTA_EXT_BOUNDARY_CHECK_EN rejects bursts that cross a 128 KiB region (cmd_err pulse).
module rosetta_ext_burst_master #(
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned RDQ_DEPTH = 4
) (
    input logic ext_clk,
    input logic ext_rst_n,
    rosetta_ext_burst_master_if.master bus
);
    localparam int unsigned AW = (RDQ_DEPTH > 1) ? $clog2(RDQ_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    state_t       state;
    logic [12:0]  beat_idx;
    logic [8:0]   beats_left;
    logic         reject_q;
    logic [12:0]  ext_idx_q;
    logic [511:0] ext_wdata_q;
    logic [63:0]  ext_we_q;
    logic         ext_en_q;
    logic         ext_last_q;
    logic [RD_LAT-1:0] pipe_vld;
    logic [RD_LAT-1:0] pipe_last;
    logic [511:0] fifo_data [RDQ_DEPTH];
    logic         fifo_last [RDQ_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]  fifo_count;
    logic [7:0]   inflight;
    logic [8:0]   occupancy;
    logic         rd_space;
    logic         ext_rd;
    logic         cmd_fire;
    logic         cmd_cross;
    logic [12:0]  cmd_start;
    logic         push;
    logic         pop;
    logic         unused_addr_bits;

    assign cmd_start        = bus.cmd_addr[18:6];
    assign unused_addr_bits = ^bus.cmd_addr[5:0];
    assign cmd_fire         = bus.cmd_valid && bus.cmd_ready;
    assign ext_rd           = ext_en_q && (ext_we_q == '0);

`ifdef ROSETTA_EXT_BOUNDARY_CHECK_EN
    logic [12:0] cmd_end;
    logic        cmd_err_q;
    assign cmd_end   = cmd_start + 13'(bus.cmd_len);
    assign cmd_cross = (cmd_end[12:11] != cmd_start[12:11]);
    always_ff @(posedge ext_clk or negedge ext_rst_n) begin
        if (!ext_rst_n) cmd_err_q <= 1'b0;
        else            cmd_err_q <= cmd_fire && cmd_cross;
    end
    assign bus.cmd_err = cmd_err_q;
`else
    assign cmd_cross   = 1'b0;
    assign bus.cmd_err = 1'b0;
`endif

    // Reads issued but not yet in the FIFO: the beat on the port plus the latency pipe.
    always_comb begin
        inflight = {7'd0, ext_rd};
        for (int unsigned i = 0; i < RD_LAT; i++) inflight = inflight + {7'd0, pipe_vld[i]};
    end

    assign occupancy = {1'b0, inflight} + 9'(fifo_count);
    assign rd_space  = occupancy < 9'(RDQ_DEPTH);

    assign bus.cmd_ready      = (state == IDLE) && ext_rst_n;
    assign bus.wr_ready       = (state == WRITE);
    assign bus.busy           = (state != IDLE) || (inflight != '0);
    assign bus.ext_addr_512b  = {ext_idx_q, 6'd0};
    assign bus.ext_wdata_512b = ext_wdata_q;
    assign bus.ext_we_512b    = ext_we_q;
    assign bus.ext_en_512b    = ext_en_q;

    always_ff @(posedge ext_clk or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            state       <= IDLE;
            beat_idx    <= '0;
            beats_left  <= '0;
            reject_q    <= 1'b0;
            ext_idx_q   <= '0;
            ext_wdata_q <= '0;
            ext_we_q    <= '0;
            ext_en_q    <= 1'b0;
            ext_last_q  <= 1'b0;
        end else begin
            ext_en_q   <= 1'b0;
            ext_we_q   <= '0;
            ext_last_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        beat_idx   <= cmd_start;
                        beats_left <= {1'b0, bus.cmd_len} + 9'd1;
                        reject_q   <= cmd_cross;
                        if (bus.cmd_write) begin
                            state <= WRITE;
                        end else if (cmd_cross) begin
                            state <= IDLE;
                        end else if (rd_space) begin
                            // First read beat goes out on the accept edge.
                            ext_en_q   <= 1'b1;
                            ext_idx_q  <= cmd_start;
                            ext_last_q <= (bus.cmd_len == 8'd0);
                            beat_idx   <= cmd_start + 13'd1;
                            beats_left <= {1'b0, bus.cmd_len};
                            state      <= (bus.cmd_len == 8'd0) ? DRAIN : READ;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                WRITE: begin
                    if (bus.wr_valid) begin
                        if (!reject_q) begin
                            ext_en_q    <= (bus.wr_strb != '0);
                            ext_we_q    <= bus.wr_strb;
                            ext_wdata_q <= bus.wr_data;
                            ext_idx_q   <= beat_idx;
                        end
                        beat_idx   <= beat_idx + 13'd1;
                        beats_left <= beats_left - 9'd1;
                        if (beats_left == 9'd1) state <= IDLE;
                    end
                end
                READ: begin
                    if (rd_space) begin
                        ext_en_q   <= 1'b1;
                        ext_idx_q  <= beat_idx;
                        ext_last_q <= (beats_left == 9'd1);
                        beat_idx   <= beat_idx + 13'd1;
                        beats_left <= beats_left - 9'd1;
                        if (beats_left == 9'd1) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (inflight == '0) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign push = pipe_vld[RD_LAT-1];
    assign pop  = bus.rd_valid && bus.rd_ready;

    always_ff @(posedge ext_clk or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            pipe_vld   <= '0;
            pipe_last  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int unsigned i = 0; i < RDQ_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_last[i] <= 1'b0;
            end
        end else begin
            pipe_vld[0]  <= ext_rd;
            pipe_last[0] <= ext_rd && ext_last_q;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_last[i] <= pipe_last[i-1];
            end
            if (push) begin
                fifo_data[wr_ptr] <= bus.ext_rdata_512b;
                fifo_last[wr_ptr] <= pipe_last[RD_LAT-1];
                wr_ptr            <= wr_ptr + (AW)'(1);
            end
            if (pop) rd_ptr <= rd_ptr + (AW)'(1);
            if (push && !pop)      fifo_count <= fifo_count + (AW+1)'(1);
            else if (!push && pop) fifo_count <= fifo_count - (AW+1)'(1);
        end
    end

    assign bus.rd_valid = (fifo_count != '0);
    assign bus.rd_data  = fifo_data[rd_ptr];
    assign bus.rd_last  = bus.rd_valid && fifo_last[rd_ptr];
endmodule

// File: tb/tb_rosetta_ext_burst_master.sv
// Scoreboard bench for rosetta_ext_burst_master: stimulus pushes expected port beats and read beats,
// a negedge monitor pops and compares them. Follows ROSETTA_EXT_BOUNDARY_CHECK_EN when defined.
module tb_rosetta_ext_burst_master;
    localparam int unsigned RD_LAT    = 1;
    localparam int unsigned RDQ_DEPTH = 4;
    localparam logic [63:0] PART_STRB = 64'h0000_0000_FFFF_00FF;

    logic ext_clk = 1'b0;
    logic ext_rst_n = 1'b0;
    always #5 ext_clk = ~ext_clk;

    rosetta_ext_burst_master_if bus ();

    rosetta_ext_burst_master #(.RD_LAT(RD_LAT), .RDQ_DEPTH(RDQ_DEPTH)) dut (
        .ext_clk  (ext_clk),
        .ext_rst_n(ext_rst_n),
        .bus      (bus)
    );

    typedef struct { logic [18:0] addr; logic [63:0] we; logic [511:0] data; } ext_t;
    typedef struct { logic [511:0] data; logic last; } rd_t;

    ext_t exp_ext[$];
    rd_t  exp_rd[$];
    int unsigned n_tests = 0;
    int unsigned n_fail = 0;
    int unsigned n_ext_rd = 0;
    int unsigned n_rd_pop = 0;
    int unsigned n_err = 0;

    function automatic logic [511:0] mdat(input logic [18:0] a);
        return {8{64'hFEED_0000_0000_0000 | {45'd0, a}}};
    endfunction

    function automatic logic [511:0] wdat(input int b);
        return {16{32'hC0DE_0000 | 32'(b)}};
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory port model with one cycle of read latency.
    always @(posedge ext_clk)
        if (bus.ext_en_512b && bus.ext_we_512b == '0) bus.ext_rdata_512b <= mdat(bus.ext_addr_512b);

    initial begin : monitor
        ext_t e;
        rd_t  r;
        forever begin
            @(negedge ext_clk);
            if (ext_rst_n) begin
                if (bus.cmd_err) n_err++;
                if (bus.ext_en_512b) begin
                    if (bus.ext_we_512b == '0) n_ext_rd++;
                    if (exp_ext.size() == 0) begin
                        check("ext_en_unexpected", bus.ext_en_512b, 1'b0);
                    end else begin
                        e = exp_ext.pop_front();
                        check("ext_addr", bus.ext_addr_512b, e.addr);
                        check("ext_we", bus.ext_we_512b, e.we);
                        if (e.we != '0) check("ext_wdata", bus.ext_wdata_512b, e.data);
                    end
                end
                if (bus.rd_valid && bus.rd_ready) begin
                    n_rd_pop++;
                    if (exp_rd.size() == 0) begin
                        check("rd_unexpected", bus.rd_valid, 1'b0);
                    end else begin
                        r = exp_rd.pop_front();
                        check("rd_data", bus.rd_data, r.data);
                        check("rd_last", bus.rd_last, r.last);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge ext_clk);
        #1;
    endtask

    task automatic exp_w(input logic [18:0] a, input logic [63:0] we, input logic [511:0] d);
        exp_ext.push_back('{addr: a, we: we, data: d});
    endtask

    task automatic exp_r(input logic [18:0] a, input logic last);
        exp_ext.push_back('{addr: a, we: 64'd0, data: 512'd0});
        exp_rd.push_back('{data: mdat(a), last: last});
    endtask

    task automatic send_cmd(input logic w, input logic [18:0] a, input int len);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_len   = 8'(len);
        for (int i = 0; i < 300; i++) begin
            @(negedge ext_clk);
            if (bus.cmd_ready) break;
        end
        check("cmd_ready_wait", bus.cmd_ready, 1'b1);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic do_write(input logic [18:0] a, input int len, input int zero_b, input int part_b, input int gap_b);
        bus.wr_valid = 1'b1;
        bus.wr_data  = wdat(0);
        bus.wr_strb  = (zero_b == 0) ? 64'd0 : '1;
        send_cmd(1'b1, a, len);
        for (int b = 0; b <= len; b++) begin
            if (b == gap_b) begin
                bus.wr_valid = 1'b0;
                tick();
                tick();
            end
            bus.wr_valid = 1'b1;
            bus.wr_data  = wdat(b);
            bus.wr_strb  = (b == zero_b) ? 64'd0 : (b == part_b) ? PART_STRB : '1;
            for (int i = 0; i < 50; i++) begin
                @(negedge ext_clk);
                if (b == 0 && i == 0) check("wr_lat_first_cycle", bus.ext_en_512b, 1'b0);
                if (b == 1 && i == 0 && zero_b != 0) check("wr_lat_second_cycle", bus.ext_en_512b, 1'b1);
                if (bus.wr_ready) break;
            end
            check("wr_ready_wait", bus.wr_ready, 1'b1);
            tick();
        end
        bus.wr_valid = 1'b0;
        bus.wr_strb  = '0;
    endtask

    task automatic do_read(input logic [18:0] a, input int len, input logic rr, input logic chk_lat);
        bus.rd_ready = rr;
        send_cmd(1'b0, a, len);
        if (chk_lat) begin
            @(negedge ext_clk);
            check("rd_lat", bus.ext_en_512b, 1'b1);
        end
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge ext_clk);
            if (!bus.busy && !bus.rd_valid) break;
        end
        check("idle_busy", bus.busy, 1'b0);
        check("idle_rd_valid", bus.rd_valid, 1'b0);
        tick();
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ext_en"}, bus.ext_en_512b, 1'b0);
        check({tag, "_ext_we"}, bus.ext_we_512b, 64'd0);
        check({tag, "_ext_addr"}, bus.ext_addr_512b, 19'd0);
        check({tag, "_rd_valid"}, bus.rd_valid, 1'b0);
        check({tag, "_rd_last"}, bus.rd_last, 1'b0);
        check({tag, "_busy"}, bus.busy, 1'b0);
        check({tag, "_wr_ready"}, bus.wr_ready, 1'b0);
        check({tag, "_cmd_ready"}, bus.cmd_ready, 1'b0);
        check({tag, "_cmd_err"}, bus.cmd_err, 1'b0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int unsigned base_rd;
        int unsigned base_pop;
        int unsigned exp_err;
        exp_err       = 0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        bus.wr_strb   = '0;
        bus.rd_ready  = 1'b0;

        // Reset state
        #12;
        check_quiet("reset");
        tick();
        ext_rst_n = 1'b1;
        @(negedge ext_clk);
        check("post_reset_cmd_ready", bus.cmd_ready, 1'b1);
        tick();

        // Full-strobe write burst: 0x40, 0x80, 0xC0, 0x100
        exp_w(19'h00040, '1, wdat(0));
        exp_w(19'h00080, '1, wdat(1));
        exp_w(19'h000C0, '1, wdat(2));
        exp_w(19'h00100, '1, wdat(3));
        do_write(19'h00040, 3, -1, -1, -1);
        wait_idle(50);

        // Zero strobe on beat 1, partial on beat 2, wr_valid gap before beat 3
        exp_w(19'h01000, '1, wdat(0));
        exp_w(19'h01080, PART_STRB, wdat(2));
        exp_w(19'h010C0, '1, wdat(3));
        do_write(19'h0103F, 3, 1, 2, 3);
        wait_idle(50);

        // Streaming read, 8 beats from 0x20000
        for (int b = 0; b < 8; b++) exp_r(19'h20000 + 19'(64 * b), b == 7);
        do_read(19'h20000, 7, 1'b1, 1'b1);
        wait_idle(100);

        // Single-beat read carries rd_last
        exp_r(19'h00040, 1'b1);
        do_read(19'h00040, 0, 1'b1, 1'b1);
        wait_idle(50);

        // Backpressured read: only RDQ_DEPTH beats may issue until rd_ready returns
        for (int b = 0; b < 16; b++) exp_r(19'h00300 + 19'(64 * b), b == 15);
        base_rd  = n_ext_rd;
        base_pop = n_rd_pop;
        do_read(19'h00300, 15, 1'b0, 1'b1);
        repeat (20) tick();
        check("stall_issued", n_ext_rd - base_rd, RDQ_DEPTH);
        check("stall_rd_valid", bus.rd_valid, 1'b1);
        check("stall_busy", bus.busy, 1'b1);
        bus.rd_ready = 1'b1;
        wait_idle(300);
        check("stall_total_pops", n_rd_pop - base_pop, 16);
        check("stall_total_issued", n_ext_rd - base_rd, 16);

        // Burst across the top of the address space
`ifdef ROSETTA_EXT_BOUNDARY_CHECK_EN
        exp_err = 1;
        do_read(19'h7FFC0, 1, 1'b1, 1'b0);
        repeat (6) tick();
        check("wrap_rejected_err", n_err, 1);
        wait_idle(50);
`else
        exp_r(19'h7FFC0, 1'b0);
        exp_r(19'h00000, 1'b1);
        do_read(19'h7FFC0, 1, 1'b1, 1'b1);
        wait_idle(50);
`endif

        // Reset in the middle of a stalled read burst
        for (int b = 0; b < 16; b++) exp_r(19'h00500 + 19'(64 * b), b == 15);
        do_read(19'h00500, 15, 1'b0, 1'b1);
        repeat (3) tick();
        ext_rst_n = 1'b0;
        #1;
        check_quiet("midreset");
        exp_ext.delete();
        exp_rd.delete();
        tick();
        tick();
        ext_rst_n = 1'b1;
        @(negedge ext_clk);
        check("after_reset_cmd_ready", bus.cmd_ready, 1'b1);
        check("after_reset_rd_valid", bus.rd_valid, 1'b0);
        tick();

        // Recovery read after reset
        exp_r(19'h00080, 1'b1);
        do_read(19'h00080, 0, 1'b1, 1'b1);
        wait_idle(50);

        repeat (4) tick();
        check("ext_queue_drained", 32'(exp_ext.size()), 32'd0);
        check("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
        check("cmd_err_count", n_err, exp_err);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
